// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks destination tags for EX/MEM/WB, registers the ALU
// forward selects for EX, and drives every stall, bubble, flush and freeze
// in the five-stage core.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_flag_en,
    input  logic        id_condbr,
    input  logic        id_branch_taken,
    input  logic        id_halt,
    input  logic        if_busy,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_ex,
    output logic        flush_ifid,
    output logic        freeze_back,
    output logic [1:0]  forward_aluin1,
    output logic [1:0]  forward_aluin2,
    output logic        halted,
    output logic [15:0] stall_count
);

    // Per-stage destination tag; the halt bit lets us see HLT reach WB.
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       regwrite;
        logic       memread;
        logic       flag_en;
        logic       halt;
    } tag_t;

    typedef enum logic [1:0] {RUN, MSTALL, HALT} state_t;

    state_t     state, next_state;
    tag_t       ex_tag, mem_tag, wb_tag, id_tag;
    logic [1:0] fwd1_next, fwd2_next;
    logic       rs_ex, rt_ex, load_use, flag_use, hazard_stall;
    logic       halt_in_flight, fetch_stall, back_frozen, halt_enter;

    // A source hits a tag only if it is really read, is not r0, and the tag writes it.
    function automatic logic src_match(input logic used, input logic [3:0] src, input tag_t t);
        return used && (src != 4'd0) && t.valid && t.regwrite && (t.rd == src);
    endfunction

    // Youngest producer wins: EX result comes over the MEM path, MEM result over WB.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] src,
                                           input tag_t ex_t, input tag_t mem_t);
        if (src_match(used, src, ex_t))
            return 2'b01;
        else if (src_match(used, src, mem_t))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign id_tag = id_valid ? {1'b1, id_rd, id_regwrite, id_memread, id_flag_en, id_halt} : '0;

    assign rs_ex          = id_valid && src_match(id_uses_rs, id_rs, ex_tag);
    assign rt_ex          = id_valid && src_match(id_uses_rt, id_rt, ex_tag);
    assign load_use       = ex_tag.memread && (rs_ex || rt_ex);
    assign flag_use       = id_valid && id_condbr && ex_tag.valid && ex_tag.flag_en;
    assign hazard_stall   = load_use || flag_use;
    assign halt_in_flight = (ex_tag.valid && ex_tag.halt) || (mem_tag.valid && mem_tag.halt)
                         || (wb_tag.valid && wb_tag.halt);
    assign fetch_stall    = if_busy || (id_valid && id_halt);
    assign back_frozen    = (state == HALT) || mem_busy;
    assign halt_enter     = !back_frozen && mem_tag.valid && mem_tag.halt;

    assign fwd1_next = id_valid ? fwd_sel(id_uses_rs, id_rs, ex_tag, mem_tag) : 2'b00;
    assign fwd2_next = id_valid ? fwd_sel(id_uses_rt, id_rt, ex_tag, mem_tag) : 2'b00;

    // State register for the RUN / MSTALL / HALT controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= RUN;
        else
            state <= next_state;
    end

    // Next state: MSTALL follows mem_busy, HALT is entered when HLT reaches WB and never left.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (mem_busy)  next_state = MSTALL;
            MSTALL:  if (!mem_busy) next_state = RUN;
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
        if (halt_enter)
            next_state = HALT;
    end

    // Outputs by priority: reset, HALT, memory stall, data/flag hazard, fetch stall, branch flush.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        freeze_back = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            halted = 1'b0;
        end else if (state == HALT) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_ex   = 1'b1;
            freeze_back = 1'b1;
            halted      = 1'b1;
        end else if (mem_busy) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            freeze_back = 1'b1;
        end else if (hazard_stall) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (fetch_stall) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble_ex  = if_busy || halt_in_flight;
        end else begin
            flush_ifid = id_valid && id_branch_taken;
        end
    end

    // Tag pipeline and registered forward selects; everything holds while the back end is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_tag         <= '0;
            mem_tag        <= '0;
            wb_tag         <= '0;
            forward_aluin1 <= 2'b00;
            forward_aluin2 <= 2'b00;
        end else if (!back_frozen) begin
            ex_tag         <= bubble_ex ? '0 : id_tag;
            mem_tag        <= ex_tag;
            wb_tag         <= mem_tag;
            forward_aluin1 <= bubble_ex ? 2'b00 : fwd1_next;
            forward_aluin2 <= bubble_ex ? 2'b00 : fwd2_next;
        end
    end

    // Saturating count of PC-stall cycles, excluding the halted core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= 16'd0;
        else if (stall_pc && (state != HALT) && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed vectors for hazard_ctrl, followed by
// hand-written halt-hold and asynchronous-reset sequences.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic [3:0] rd;
        logic       rw;
        logic       mr;
        logic       fe;
        logic       cb;
        logic       bt;
        logic       hlt;
        logic       ifb;
        logic       mb;
    } in_t;

    typedef struct {
        in_t         stim;
        logic [25:0] exp;
    } vec_t;

    logic        clk, rst;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_flag_en;
    logic        id_condbr, id_branch_taken, id_halt, if_busy, mem_busy;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze_back, halted;
    logic [1:0]  forward_aluin1, forward_aluin2;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_flag_en(id_flag_en),
        .id_condbr(id_condbr), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
        .if_busy(if_busy), .mem_busy(mem_busy),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_ex(bubble_ex),
        .flush_ifid(flush_ifid), .freeze_back(freeze_back),
        .forward_aluin1(forward_aluin1), .forward_aluin2(forward_aluin2),
        .halted(halted), .stall_count(stall_count)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t nop();
        in_t r = '0;
        return r;
    endfunction

    function automatic in_t alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        in_t r = '0;
        r.valid = 1'b1; r.rs = rs; r.rt = rt; r.urs = 1'b1; r.urt = 1'b1;
        r.rd = rd; r.rw = 1'b1;
        return r;
    endfunction

    function automatic in_t lw(input logic [3:0] rd, input logic [3:0] rs);
        in_t r = '0;
        r.valid = 1'b1; r.rs = rs; r.urs = 1'b1; r.rd = rd; r.rw = 1'b1; r.mr = 1'b1;
        return r;
    endfunction

    function automatic in_t flg(input logic [3:0] rs, input logic [3:0] rt);
        in_t r = '0;
        r.valid = 1'b1; r.rs = rs; r.rt = rt; r.urs = 1'b1; r.urt = 1'b1; r.fe = 1'b1;
        return r;
    endfunction

    function automatic in_t br();
        in_t r = '0;
        r.valid = 1'b1; r.cb = 1'b1; r.bt = 1'b1;
        return r;
    endfunction

    function automatic in_t hlt();
        in_t r = '0;
        r.valid = 1'b1; r.hlt = 1'b1;
        return r;
    endfunction

    function automatic in_t with_ifb(input in_t i);
        in_t r = i;
        r.ifb = 1'b1;
        return r;
    endfunction

    function automatic in_t with_mb(input in_t i);
        in_t r = i;
        r.mb = 1'b1;
        return r;
    endfunction

    // Expected output word: {stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze_back, fwd1, fwd2, halted, stall_count}.
    function automatic logic [25:0] e(input logic spc, input logic sif, input logic bex,
                                      input logic fl, input logic frz, input logic [1:0] f1,
                                      input logic [1:0] f2, input logic hl, input logic [15:0] cnt);
        return {spc, sif, bex, fl, frz, f1, f2, hl, cnt};
    endfunction

    task automatic add(input in_t i, input logic [25:0] x);
        vec_t v;
        v.stim = i;
        v.exp  = x;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input in_t i);
        id_valid        = i.valid;
        id_rs           = i.rs;
        id_rt           = i.rt;
        id_uses_rs      = i.urs;
        id_uses_rt      = i.urt;
        id_rd           = i.rd;
        id_regwrite     = i.rw;
        id_memread      = i.mr;
        id_flag_en      = i.fe;
        id_condbr       = i.cb;
        id_branch_taken = i.bt;
        id_halt         = i.hlt;
        if_busy         = i.ifb;
        mem_busy        = i.mb;
    endtask

    task automatic check_output(input string name, input logic [25:0] exp);
        logic [25:0] got;
        got = {stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze_back,
               forward_aluin1, forward_aluin2, halted, stall_count};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Main sequence: reset, table of per-cycle vectors, then halt and async-reset corners.
    initial begin
        // ADD/SUB EX forward, MEM forward, load-use, r0 handling, flag stall + flush, fetch stall.
        add(alu(3, 1, 2),          e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));
        add(alu(4, 3, 5),          e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));
        add(alu(7, 8, 9),          e(0,0,0,0,0, 2'd1,2'd0, 0, 16'd0));
        add(alu(6, 2, 4),          e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));
        add(lw(2, 0),              e(0,0,0,0,0, 2'd0,2'd2, 0, 16'd0));
        add(alu(1, 2, 2),          e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd0));
        add(alu(1, 2, 2),          e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd1));
        add(alu(0, 1, 1),          e(0,0,0,0,0, 2'd2,2'd2, 0, 16'd1));
        add(alu(5, 0, 1),          e(0,0,0,0,0, 2'd1,2'd1, 0, 16'd1));
        add(flg(8, 9),             e(0,0,0,0,0, 2'd0,2'd2, 0, 16'd1));
        add(br(),                  e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd1));
        add(br(),                  e(0,0,0,1,0, 2'd0,2'd0, 0, 16'd2));
        add(with_ifb(nop()),       e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd2));
        add(with_ifb(br()),        e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd3));
        add(nop(),                 e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd4));
        // Three mem_busy cycles with a dependent op in ID, then release.
        add(alu(10, 1, 2),         e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd4));
        add(with_mb(alu(11,10,3)), e(1,1,0,0,1, 2'd0,2'd0, 0, 16'd4));
        add(with_mb(alu(11,10,3)), e(1,1,0,0,1, 2'd0,2'd0, 0, 16'd5));
        add(with_mb(alu(11,10,3)), e(1,1,0,0,1, 2'd0,2'd0, 0, 16'd6));
        add(alu(11, 10, 3),        e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd7));
        add(nop(),                 e(0,0,0,0,0, 2'd1,2'd0, 0, 16'd7));
        // mem_busy over a load-use: memory stall first, load-use stall after release.
        add(lw(12, 1),             e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd7));
        add(with_mb(alu(13,12,12)),e(1,1,0,0,1, 2'd0,2'd0, 0, 16'd7));
        add(alu(13, 12, 12),       e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd8));
        add(alu(13, 12, 12),       e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd9));
        add(nop(),                 e(0,0,0,0,0, 2'd2,2'd2, 0, 16'd9));
        // HLT: passes into EX once, everything behind it is bubbled, then HALT.
        add(hlt(),                 e(1,1,0,0,0, 2'd0,2'd0, 0, 16'd9));
        add(hlt(),                 e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd10));
        add(hlt(),                 e(1,1,1,0,0, 2'd0,2'd0, 0, 16'd11));
        add(nop(),                 e(1,1,1,0,1, 2'd0,2'd0, 1, 16'd12));
        add(nop(),                 e(1,1,1,0,1, 2'd0,2'd0, 1, 16'd12));

        rst = 1'b1;
        apply_stimulus(nop());
        #1 rst = 1'b0;
        #2 check_output("reset_state", e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            apply_stimulus(vecs[k].stim);
            #1 check_output($sformatf("vec%0d", k), vecs[k].exp);
        end

        // HALT holds regardless of inputs; async reset then clears everything at once.
        @(negedge clk);
        apply_stimulus(with_mb(with_ifb(nop())));
        #1 check_output("halt_hold", e(1,1,1,0,1, 2'd0,2'd0, 1, 16'd12));
        rst = 1'b0;
        #1 check_output("async_reset", e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));

        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(alu(1, 2, 3));
        #1 check_output("run_after_reset", e(0,0,0,0,0, 2'd0,2'd0, 0, 16'd0));
        @(negedge clk);
        apply_stimulus(with_mb(alu(4, 1, 5)));
        #1 check_output("mstall_after_reset", e(1,1,0,0,1, 2'd0,2'd0, 0, 16'd0));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
